// File: rtl/immediate_encoder_if.sv
// -----------------------------------------------------------------------------
// immediate_encoder_if
// Request/result bundle for the immediate encoder.
//   start  : request strobe (master -> slave), only honoured while idle
//   value  : 8-bit constant to encode (master -> slave)
//   busy   : encoder is not idle (slave -> master)
//   done   : one-cycle pulse, result valid (slave -> master)
//   found  : constant is encodable (slave -> master)
//   code   : 5-bit immediate field, code[4]=1 table form, 0 direct form
// -----------------------------------------------------------------------------
interface immediate_encoder_if;
   logic       start;
   logic [7:0] value;
   logic       busy;
   logic       done;
   logic       found;
   logic [4:0] code;

   modport master (
      output start, value,
      input  busy, done, found, code
   );

   modport slave (
      input  start, value,
      output busy, done, found, code
   );
endinterface

// File: rtl/immediate_encoder.sv
// -----------------------------------------------------------------------------
// immediate_encoder
// Finds the 5-bit immediate field that the immediate decoder expands back to
// a given 8-bit constant. Constants 0..15 use the direct form; anything else
// is looked up in the decoder's 16-entry table, one entry per cycle, and the
// lowest matching index is reported.
// Ports:
//   i_clk  : system clock, rising edge
//   i_rst  : synchronous active-high reset
//   bus    : immediate_encoder_if.slave (start/value in; busy/done/found/code out)
// -----------------------------------------------------------------------------
module immediate_encoder (
   input  logic                 i_clk,
   input  logic                 i_rst,
   immediate_encoder_if.slave   bus
);

   // CHECK is the cycle after acceptance where the latched constant is
   // classified as direct or table form.
   typedef enum logic [1:0] {
      S_IDLE,
      S_CHECK,
      S_SEARCH,
      S_DONE
   } state_t;

   state_t     r_state;
   logic [7:0] r_value;
   logic [3:0] r_idx;
   logic       r_busy;
   logic       r_done;
   logic       r_found;
   logic [4:0] r_code;
   logic       w_match;

   // Must stay identical to the immediate decoder's table.
   function automatic logic [7:0] table_entry(input logic [3:0] idx);
      case (idx)
         4'h0:    table_entry = 8'hF1;
         4'h1:    table_entry = 8'h80;
         4'h2:    table_entry = 8'h81;
         4'h3:    table_entry = 8'hC8;
         4'h4:    table_entry = 8'h82;
         4'h5:    table_entry = 8'h26;
         4'h6:    table_entry = 8'hD7;
         4'h7:    table_entry = 8'h40;
         4'h8:    table_entry = 8'h00;
         4'h9:    table_entry = 8'hF5;
         4'hA:    table_entry = 8'h80;
         4'hB:    table_entry = 8'h4A;
         4'hC:    table_entry = 8'hF0;
         default: table_entry = 8'h00;
      endcase
   endfunction

   assign w_match = (table_entry(r_idx) == r_value);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_value <= 8'h00;
         r_idx   <= 4'h0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_found <= 1'b0;
         r_code  <= 5'h00;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_value <= bus.value;
                  r_found <= 1'b0;
                  r_code  <= 5'h00;
                  r_idx   <= 4'h0;
                  r_busy  <= 1'b1;
                  r_state <= S_CHECK;
               end
            end

            S_CHECK: begin
               // Direct form has priority over any table entry (e.g. 0x00).
               if (r_value < 8'd16) begin
                  r_found <= 1'b1;
                  r_code  <= {1'b0, r_value[3:0]};
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_state <= S_SEARCH;
               end
            end

            S_SEARCH: begin
               // Ascending scan, so the first hit is the lowest duplicate.
               if (w_match) begin
                  r_found <= 1'b1;
                  r_code  <= {1'b1, r_idx};
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else if (r_idx == 4'hF) begin
                  r_found <= 1'b0;
                  r_code  <= 5'h00;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_idx <= r_idx + 4'h1;
               end
            end

            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy  = r_busy;
   assign bus.done  = r_done;
   assign bus.found = r_found;
   assign bus.code  = r_code;

endmodule

// File: tb/tb_immediate_encoder.sv
// -----------------------------------------------------------------------------
// tb_immediate_encoder
// Self-checking bench for immediate_encoder. A behavioural model searches
// the decoder table directly and predicts found, code and latency (edges
// from acceptance to the done cycle).
// -----------------------------------------------------------------------------
module tb_immediate_encoder;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp  = 0;
   int   n_fail = 0;

   immediate_encoder_if bif ();

   immediate_encoder dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bif)
   );

   always #5 clk = ~clk;

   logic [7:0] tbl [16] = '{8'hF1, 8'h80, 8'h81, 8'hC8, 8'h82, 8'h26, 8'hD7, 8'h40,
                            8'h00, 8'hF5, 8'h80, 8'h4A, 8'hF0, 8'h00, 8'h00, 8'h00};

   task automatic ref_model(input logic [7:0] v, output logic f, output logic [4:0] c,
                            output int lat);
      f = 1'b0; c = 5'h00; lat = 17;
      if (v < 16) begin
         f = 1'b1; c = {1'b0, v[3:0]}; lat = 1;
      end else begin
         for (int k = 15; k >= 0; k--) begin
            if (tbl[k] == v) begin
               f = 1'b1; c = 5'h10 + 5'(k); lat = k + 2;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request from IDLE, wait (bounded) for done, then step one
   // more cycle so the DUT is back in IDLE.
   task automatic do_op(input logic [7:0] v, output int lat, output logic f,
                        output logic [4:0] c, output logic post_busy,
                        output logic [4:0] post_code);
      bif.start = 1'b1;
      bif.value = v;
      tick();
      bif.start = 1'b0;
      bif.value = 8'($urandom);
      lat = -1; f = 1'bx; c = 5'hxx;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (bif.done === 1'b1) begin
            lat = i; f = bif.found; c = bif.code;
            break;
         end
      end
      tick();
      post_busy = bif.busy;
      post_code = bif.code;
   endtask

   task automatic check_op(input string name, input logic [7:0] v);
      int lat, elat;
      logic f, ef, pb;
      logic [4:0] c, ec, pc;
      ref_model(v, ef, ec, elat);
      do_op(v, lat, f, c, pb, pc);
      n_cmp++;
      if (lat !== elat || f !== ef || c !== ec) begin
         n_fail++;
         $display("FAIL %s v=%h: got lat=%0d found=%b code=%h, want lat=%0d found=%b code=%h",
                  name, v, lat, f, c, elat, ef, ec);
      end
      n_cmp++;
      if (pb !== 1'b0 || pc !== ec) begin
         n_fail++;
         $display("FAIL %s_after v=%h: got busy=%b code=%h, want busy=0 code=%h",
                  name, v, pb, pc, ec);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bif.start = 1'b1;
      bif.value = 8'h05;
      tick();
      tick();
      n_cmp++;
      if ({bif.busy, bif.done, bif.found, bif.code} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset: got busy=%b done=%b found=%b code=%h, want all 0",
                  bif.busy, bif.done, bif.found, bif.code);
      end
      bif.start = 1'b0;
      rst = 1'b0;
      tick();
      n_cmp++;
      if (bif.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: got busy=%b want 0", bif.busy);
      end
   endtask

   task automatic test_direct();
      check_op("direct_0a", 8'h0A);
      check_op("direct_00", 8'h00);
      check_op("direct_0f", 8'h0F);
   endtask

   task automatic test_table();
      check_op("dup_80", 8'h80);
      check_op("tbl_f1", 8'hF1);
      check_op("tbl_f0", 8'hF0);
      check_op("nomatch_55", 8'h55);
      check_op("nomatch_10", 8'h10);
   endtask

   task automatic test_ignore_start();
      int lat = -1;
      logic [4:0] c = 5'h00;
      bif.start = 1'b1;
      bif.value = 8'hF0;
      tick();
      bif.start = 1'b0;
      tick(); tick();
      bif.start = 1'b1;
      bif.value = 8'h26;
      tick();
      bif.start = 1'b0;
      for (int i = 4; i <= 40; i++) begin
         tick();
         if (bif.done === 1'b1) begin
            lat = i; c = bif.code;
            break;
         end
      end
      tick();
      n_cmp++;
      if (lat !== 14 || c !== 5'h1C) begin
         n_fail++;
         $display("FAIL ignore_start: got lat=%0d code=%h, want lat=14 code=1c", lat, c);
      end
      check_op("after_ignore_26", 8'h26);
   endtask

   task automatic test_back_to_back();
      bif.start = 1'b1;
      bif.value = 8'h0A;
      tick();               // accepted
      tick();               // DONE, start still high
      n_cmp++;
      if (bif.done !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_done1: got done=%b want 1", bif.done);
      end
      tick();               // back in IDLE; start during DONE ignored
      n_cmp++;
      if (bif.busy !== 1'b0 || bif.done !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_gap: got busy=%b done=%b want 0 0", bif.busy, bif.done);
      end
      bif.value = 8'h07;
      tick();               // second accept
      bif.start = 1'b0;
      n_cmp++;
      if (bif.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_accept: got busy=%b want 1", bif.busy);
      end
      tick();
      n_cmp++;
      if (bif.done !== 1'b1 || bif.code !== 5'h07) begin
         n_fail++;
         $display("FAIL b2b_done2: got done=%b code=%h want 1 07", bif.done, bif.code);
      end
      tick();
   endtask

   task automatic test_reset_abort();
      int late = 0;
      bif.start = 1'b1;
      bif.value = 8'h4A;
      tick();               // edge t
      bif.start = 1'b0;
      tick(); tick(); tick(); tick();
      rst = 1'b1;
      tick();               // edge t+5
      n_cmp++;
      if ({bif.busy, bif.done, bif.found, bif.code} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_abort: got busy=%b done=%b found=%b code=%h, want all 0",
                  bif.busy, bif.done, bif.found, bif.code);
      end
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bif.done === 1'b1 || bif.busy === 1'b1) late++;
      end
      n_cmp++;
      if (late !== 0) begin
         n_fail++;
         $display("FAIL reset_abort_late: got %0d active cycles, want 0", late);
      end
   endtask

   task automatic test_random();
      logic [7:0] v;
      for (int n = 0; n < 24; n++) begin
         if ($urandom_range(0, 1) == 1) v = tbl[$urandom_range(0, 15)];
         else v = 8'($urandom);
         check_op("random", v);
      end
   endtask

   initial begin
      bif.start = 1'b0;
      bif.value = 8'h00;
      tick();
      test_reset();
      test_direct();
      test_table();
      test_ignore_start();
      test_back_to_back();
      test_reset_abort();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
